audio_mixer: RTL and testbench

//  Sequential stereo mixer upstream of the I2S DAC serialiser. On each sample

---
 rtl/audio_mixer.sv | 179 +++++++++++++++++
 tb/tb_audio_mixer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mixer.sv
// audio_mixer: sequential stereo mixer (beeper/EAR/MIC + AY A/B/C) feeding the I2S serialiser.
// Optional DC-blocking high-pass stage: define AUDIO_MIXER_DCBLOCK_EN.
module audio_mixer #(
  parameter logic [15:0] BEEP_LVL = 16'h2000,
  parameter logic [15:0] EAR_LVL  = 16'h1000,
  parameter logic [15:0] MIC_LVL  = 16'h0400,
  parameter int          AY_SHIFT = 5,
  parameter int          STEREO   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        strb,
  input  logic        speaker,
  input  logic        ear,
  input  logic        mic,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  c,
  output logic [15:0] ldata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        valid
);

  typedef enum logic [3:0] {
    S_IDLE, S_SPK, S_EAR, S_MIC, S_CHA, S_CHB, S_CHC, S_SAT, S_DCB
  } state_t;

  state_t      r_state;
  logic        r_spk, r_ear, r_mic;
  logic [7:0]  r_a, r_b, r_c;
  logic [17:0] r_accL, r_accR;
  logic [15:0] r_ldata, r_rdata;
  logic        r_busy, r_valid;

  logic [17:0] w_termA, w_termB, w_termC;
  logic [15:0] w_clampL, w_clampR, w_sL, w_sR;

  assign w_termA = {10'd0, r_a} << AY_SHIFT;
  assign w_termB = {10'd0, r_b} << AY_SHIFT;
  assign w_termC = {10'd0, r_c} << AY_SHIFT;

  // Unsigned accumulator is offset binary; flipping the MSB yields two's complement.
  assign w_clampL = (r_accL > 18'h0FFFF) ? 16'hFFFF : r_accL[15:0];
  assign w_clampR = (r_accR > 18'h0FFFF) ? 16'hFFFF : r_accR[15:0];
  assign w_sL     = {~w_clampL[15], w_clampL[14:0]};
  assign w_sR     = {~w_clampR[15], w_clampR[14:0]};

  assign ldata = r_ldata;
  assign rdata = r_rdata;
  assign busy  = r_busy;
  assign valid = r_valid;

`ifdef AUDIO_MIXER_DCBLOCK_EN
  logic [15:0]        r_xL, r_xR, r_xPrevL, r_xPrevR;
  logic signed [19:0] r_yPrevL, r_yPrevR;
  logic [15:0]        w_yL, w_yR;

  function automatic logic [15:0] dcStep(input logic [15:0] x, input logic [15:0] xp,
                                         input logic signed [19:0] yp);
    logic signed [19:0] v;
    v = $signed({{4{x[15]}}, x}) - $signed({{4{xp[15]}}, xp}) + yp - (yp >>> 8);
    if (v > 20'sd32767)       dcStep = 16'h7FFF;
    else if (v < -20'sd32768) dcStep = 16'h8000;
    else                      dcStep = v[15:0];
  endfunction

  assign w_yL = dcStep(r_xL, r_xPrevL, r_yPrevL);
  assign w_yR = dcStep(r_xR, r_xPrevR, r_yPrevR);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_spk   <= 1'b0;
      r_ear   <= 1'b0;
      r_mic   <= 1'b0;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_c     <= 8'd0;
      r_accL  <= 18'd0;
      r_accR  <= 18'd0;
      r_ldata <= 16'h0000;
      r_rdata <= 16'h0000;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
`ifdef AUDIO_MIXER_DCBLOCK_EN
      r_xL     <= 16'd0;
      r_xR     <= 16'd0;
      r_xPrevL <= 16'd0;
      r_xPrevR <= 16'd0;
      r_yPrevL <= 20'sd0;
      r_yPrevR <= 20'sd0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (strb) begin
            r_spk   <= speaker;
            r_ear   <= ear;
            r_mic   <= mic;
            r_a     <= a;
            r_b     <= b;
            r_c     <= c;
            r_accL  <= 18'd0;
            r_accR  <= 18'd0;
            r_busy  <= 1'b1;
            r_state <= S_SPK;
          end
        end
        S_SPK: begin
          if (r_spk) begin
            r_accL <= r_accL + {2'b00, BEEP_LVL};
            r_accR <= r_accR + {2'b00, BEEP_LVL};
          end
          r_state <= S_EAR;
        end
        S_EAR: begin
          if (r_ear) begin
            r_accL <= r_accL + {2'b00, EAR_LVL};
            r_accR <= r_accR + {2'b00, EAR_LVL};
          end
          r_state <= S_MIC;
        end
        S_MIC: begin
          if (r_mic) begin
            r_accL <= r_accL + {2'b00, MIC_LVL};
            r_accR <= r_accR + {2'b00, MIC_LVL};
          end
          r_state <= S_CHA;
        end
        S_CHA: begin
          r_accL <= r_accL + w_termA;
          if (STEREO == 0) r_accR <= r_accR + w_termA;
          r_state <= S_CHB;
        end
        S_CHB: begin
          r_accL  <= r_accL + w_termB;
          r_accR  <= r_accR + w_termB;
          r_state <= S_CHC;
        end
        S_CHC: begin
          r_accR <= r_accR + w_termC;
          if (STEREO == 0) r_accL <= r_accL + w_termC;
          r_state <= S_SAT;
        end
        S_SAT: begin
`ifdef AUDIO_MIXER_DCBLOCK_EN
          r_xL    <= w_sL;
          r_xR    <= w_sR;
          r_state <= S_DCB;
`else
          r_ldata <= w_sL;
          r_rdata <= w_sR;
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
          r_state <= S_IDLE;
`endif
        end
`ifdef AUDIO_MIXER_DCBLOCK_EN
        S_DCB: begin
          r_ldata  <= w_yL;
          r_rdata  <= w_yR;
          r_xPrevL <= r_xL;
          r_xPrevR <= r_xR;
          r_yPrevL <= {{4{w_yL[15]}}, w_yL};
          r_yPrevR <= {{4{w_yR[15]}}, w_yR};
          r_busy   <= 1'b0;
          r_valid  <= 1'b1;
          r_state  <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer: three audio_mixer instances (default, mono, loud beeper) checked
// every cycle against a sample-level model, plus hand-computed literal results.
module tb_audio_mixer;

`ifdef AUDIO_MIXER_DCBLOCK_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       strb = 1'b0;
  logic       speaker = 1'b0, ear = 1'b0, mic = 1'b0;
  logic [7:0] a = 8'd0, b = 8'd0, c = 8'd0;

  logic [15:0] ldat [3];
  logic [15:0] rdat [3];
  logic        bsy  [3];
  logic        vld  [3];

  int  nChecks = 0;
  int  nErrors = 0;
  bit  checkEn = 1'b0;

  always #5 clock = ~clock;

  audio_mixer uDef (
    .clock(clock), .reset(reset), .strb(strb), .speaker(speaker), .ear(ear), .mic(mic),
    .a(a), .b(b), .c(c), .ldata(ldat[0]), .rdata(rdat[0]), .busy(bsy[0]), .valid(vld[0]));

  audio_mixer #(.STEREO(0)) uMono (
    .clock(clock), .reset(reset), .strb(strb), .speaker(speaker), .ear(ear), .mic(mic),
    .a(a), .b(b), .c(c), .ldata(ldat[1]), .rdata(rdat[1]), .busy(bsy[1]), .valid(vld[1]));

  audio_mixer #(.BEEP_LVL(16'hF000)) uLoud (
    .clock(clock), .reset(reset), .strb(strb), .speaker(speaker), .ear(ear), .mic(mic),
    .a(a), .b(b), .c(c), .ldata(ldat[2]), .rdata(rdat[2]), .busy(bsy[2]), .valid(vld[2]));

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  // Sample-level model: a mix is the saturated sum of weighted sources,
  // re-centred to signed by subtracting the mid-scale offset.
  function automatic int mixSide(input int k, input bit left, input bit spk, input bit e,
                                 input bit m, input int aa, input int bb, input int cc);
    int s;
    s = 0;
    if (spk) s += (k == 2) ? 32'hF000 : 32'h2000;
    if (e)   s += 32'h1000;
    if (m)   s += 32'h0400;
    if (k == 1)    s += 32 * (aa + bb + cc);
    else if (left) s += 32 * (aa + bb);
    else           s += 32 * (bb + cc);
    if (s > 65535) s = 65535;
    return s - 32768;
  endfunction

  function automatic int dcb(input int x, input int xp, input int yp);
    int y;
    y = x - xp + yp - (yp >>> 8);
    if (y > 32767)  y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  int mCnt [3];
  int mL [3], mR [3], pL [3], pR [3];
  int xpL [3], xpR [3], ypL [3], ypR [3];
  bit mV [3];

  always @(posedge clock) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        mCnt[k] <= 0; mV[k] <= 1'b0; mL[k] <= 0; mR[k] <= 0;
        xpL[k] <= 0; xpR[k] <= 0; ypL[k] <= 0; ypR[k] <= 0;
      end else begin
        mV[k] <= 1'b0;
        if (mCnt[k] != 0) begin
          mCnt[k] <= mCnt[k] - 1;
          if (mCnt[k] == 1) begin
`ifdef AUDIO_MIXER_DCBLOCK_EN
            mL[k]  <= dcb(pL[k], xpL[k], ypL[k]);
            ypL[k] <= dcb(pL[k], xpL[k], ypL[k]);
            xpL[k] <= pL[k];
            mR[k]  <= dcb(pR[k], xpR[k], ypR[k]);
            ypR[k] <= dcb(pR[k], xpR[k], ypR[k]);
            xpR[k] <= pR[k];
`else
            mL[k] <= pL[k];
            mR[k] <= pR[k];
`endif
            mV[k] <= 1'b1;
          end
        end else if (strb) begin
          mCnt[k] <= LAT - 1;
          pL[k] <= mixSide(k, 1'b1, speaker, ear, mic, int'(a), int'(b), int'(c));
          pR[k] <= mixSide(k, 1'b0, speaker, ear, mic, int'(a), int'(b), int'(c));
        end
      end
    end
  end

  always @(negedge clock) begin
    if (checkEn) begin
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("busy%0d", k), int'(bsy[k]), int'(mCnt[k] != 0));
        checkOutput($sformatf("valid%0d", k), int'(vld[k]), int'(mV[k]));
        checkOutput($sformatf("ldata%0d", k), int'($signed(ldat[k])), mL[k]);
        checkOutput($sformatf("rdata%0d", k), int'($signed(rdat[k])), mR[k]);
      end
    end
  end

  // Pulse strb for one clock with the given sources, then scramble the
  // inputs so only the snapshot can produce the right answer.
  task automatic applyStimulus(input bit spk, input bit e, input bit m,
                               input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] cc);
    @(posedge clock); #2;
    speaker = spk; ear = e; mic = m; a = aa; b = bb; c = cc;
    strb = 1'b1;
    @(posedge clock); #2;
    strb = 1'b0;
    speaker = 1'($urandom); ear = 1'($urandom); mic = 1'($urandom);
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
  endtask

  task automatic waitValid(input string name, input int expLat);
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      lat++;
      if (vld[0]) seen = 1'b1;
    end
    checkOutput({name, "_latency"}, seen ? lat : -1, expLat);
  endtask

  initial begin
    int nV;
    repeat (2) @(posedge clock);
    #2 checkEn = 1'b1;
    @(negedge clock);
    checkOutput("rst_ldata", int'(ldat[0]), 0);
    checkOutput("rst_rdata", int'(rdat[0]), 0);
    checkOutput("rst_busy",  int'(bsy[0]), 0);
    checkOutput("rst_valid", int'(vld[0]), 0);
    @(posedge clock); #2 reset = 1'b0;

    applyStimulus(0, 0, 0, 8'h00, 8'h00, 8'h00);
    waitValid("silence", LAT);
`ifndef AUDIO_MIXER_DCBLOCK_EN
    checkOutput("silence_l", int'(ldat[0]), 32'h8000);
    checkOutput("silence_r", int'(rdat[0]), 32'h8000);

    applyStimulus(1, 0, 0, 8'h00, 8'h00, 8'h00);
    waitValid("beep", LAT);
    checkOutput("beep_l", int'(ldat[0]), 32'hA000);
    checkOutput("beep_r", int'(rdat[0]), 32'hA000);
    checkOutput("beepLoud_l", int'(ldat[2]), 32'h7000);

    applyStimulus(1, 1, 1, 8'h00, 8'h00, 8'h00);
    waitValid("bits", LAT);
    checkOutput("bits_l", int'(ldat[0]), 32'hB400);
    checkOutput("bits_r", int'(rdat[0]), 32'hB400);

    applyStimulus(0, 0, 0, 8'hFF, 8'h00, 8'h00);
    waitValid("chA", LAT);
    checkOutput("chA_l", int'(ldat[0]), 32'h9FE0);
    checkOutput("chA_r", int'(rdat[0]), 32'h8000);
    checkOutput("chAmono_l", int'(ldat[1]), 32'h9FE0);
    checkOutput("chAmono_r", int'(rdat[1]), 32'h9FE0);

    applyStimulus(0, 0, 0, 8'h00, 8'h00, 8'hFF);
    waitValid("chC", LAT);
    checkOutput("chC_l", int'(ldat[0]), 32'h8000);
    checkOutput("chC_r", int'(rdat[0]), 32'h9FE0);

    applyStimulus(0, 0, 0, 8'h00, 8'hFF, 8'h00);
    waitValid("chB", LAT);
    checkOutput("chB_l", int'(ldat[0]), 32'h9FE0);
    checkOutput("chB_r", int'(rdat[0]), 32'h9FE0);

    applyStimulus(1, 1, 1, 8'hFF, 8'hFF, 8'hFF);
    waitValid("full", LAT);
    checkOutput("fullLoud_l", int'(ldat[2]), 32'h7FFF);
    checkOutput("fullLoud_r", int'(rdat[2]), 32'h7FFF);
    checkOutput("full_l", int'(ldat[0]), 32'hF3C0);
`else
    applyStimulus(1, 1, 1, 8'hFF, 8'hFF, 8'hFF);
    waitValid("full", LAT);
`endif

    // A second strobe three clocks in is dropped; one in the valid cycle is taken.
    applyStimulus(1, 0, 0, 8'h12, 8'h34, 8'h56);
    repeat (2) @(posedge clock);
    #2 strb = 1'b1;
    @(posedge clock); #2 strb = 1'b0;
    waitValid("ignored", LAT - 3);
    strb = 1'b1;
    @(posedge clock); #2 strb = 1'b0;
    waitValid("backToBack", LAT);
    nV = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (vld[0]) nV++;
    end
    checkOutput("noExtraValid", nV, 0);

    // Reset during CHA aborts the mix.
    applyStimulus(1, 1, 0, 8'h40, 8'h40, 8'h40);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("chaBusy", int'(bsy[0]), 1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("abort_busy",  int'(bsy[0]), 0);
    checkOutput("abort_ldata", int'(ldat[0]), 0);
    checkOutput("abort_rdata", int'(rdat[0]), 0);
    checkOutput("abort_valid", int'(vld[0]), 0);
    @(posedge clock); #2 reset = 1'b0;
    nV = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (vld[0]) nV++;
    end
    checkOutput("abort_noValid", nV, 0);

`ifdef AUDIO_MIXER_DCBLOCK_EN
    for (int n = 0; n < 2000; n++) begin
      applyStimulus(1, 0, 0, 8'h00, 8'h00, 8'h00);
      repeat (LAT - 1) @(posedge clock);
    end
    @(negedge clock);
    checkOutput("dcDecay", ($signed(ldat[0]) < 16'sh0040 && $signed(ldat[0]) > -16'sh0040) ? 1 : 0, 1);
`endif

    applyStimulus(0, 1, 0, 8'h01, 8'h02, 8'h03);
    waitValid("final", LAT);
    repeat (2) @(negedge clock);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
